// File: rtl/bus_slave_port_if.sv
// ---------------------------------------------------------------------------
// bus_slave_port_if
//   Bit-serial system bus between a command_processor (master) and one
//   bus_slave_port (slave).
//
//   Handshake: the master holds bus_valid high for the whole frame. It
//   presents one 2-bit beat on data_write per clock, MSB pair first. The
//   slave answers reads on data_read, one beat per clock, qualified by
//   read_valid. There is no back-pressure. A frame that loses bus_valid
//   before it completes is truncated (aborted).
//
//   Signals:
//     bus_valid  master -> slave  frame strobe
//     bus_rw     master -> slave  1 = write, 0 = read (first frame cycle only)
//     data_write master -> slave  address beats, then write-data beats
//     data_read  slave -> master  read-data beats (zero when not valid)
//     read_valid slave -> master  data_read carries a beat this cycle
// ---------------------------------------------------------------------------
interface bus_slave_port_if;
    logic       bus_valid;
    logic       bus_rw;
    logic [1:0] data_write;
    logic [1:0] data_read;
    logic       read_valid;

    modport master (
        output bus_valid,
        output bus_rw,
        output data_write,
        input  data_read,
        input  read_valid
    );

    modport slave (
        input  bus_valid,
        input  bus_rw,
        input  data_write,
        output data_read,
        output read_valid
    );
endinterface

// File: rtl/bus_slave_port.sv
// ---------------------------------------------------------------------------
// bus_slave_port
//   Slave endpoint of the 2-bit bit-serial bus. Write frames are deserialised
//   into a small register memory. Read frames return the addressed word one
//   beat per clock on the read lane.
//
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous, active-high reset
//     bus          bus_slave_port_if.slave (bus_valid, bus_rw, data_write,
//                  data_read, read_valid)
//     wr_done      one-cycle pulse after a completed write
//     frame_abort  one-cycle pulse after a truncated frame
//     busy         high whenever the FSM is not IDLE
//     last_wdata   last word committed to memory
//     abort_count  saturating count of aborts (BUS_SLAVE_ABORT_CNT_EN only)
//     dbg_state_o  current FSM state, for debug and checkers
//
//   Optional feature macro: BUS_SLAVE_ABORT_CNT_EN adds the abort_count port.
// ---------------------------------------------------------------------------
module bus_slave_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_slave_port_if.slave       bus,
    output logic                  wr_done,
    output logic                  frame_abort,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] last_wdata,
`ifdef BUS_SLAVE_ABORT_CNT_EN
    output logic [7:0]            abort_count,
`endif
    output logic [2:0]            dbg_state_o
);

    localparam int ADDR_BEATS = ADDR_WIDTH / 2;
    localparam int DATA_BEATS = DATA_WIDTH / 2;
    localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
    localparam int CW         = $clog2(MAX_BEATS + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BEATS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RWAIT = 3'd3,
        S_RDATA = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wsh_q, wsh_d;
    logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
    logic                  rw_q, rw_d;
    logic                  wr_done_q, wr_done_d;
    logic                  abort_q, abort_d;
    logic [DATA_WIDTH-1:0] last_wdata_q;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Next-state and datapath control. Losing bus_valid inside a frame
    // always wins over capturing or presenting a beat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wsh_d     = wsh_q;
        rsh_d     = rsh_q;
        rw_d      = rw_q;
        wr_done_d = 1'b0;
        abort_d   = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.bus_valid) begin
                    rw_d   = bus.bus_rw;
                    addr_d = ADDR_WIDTH'({addr_q, bus.data_write});
                    if (ADDR_BEATS == 1) begin
                        cnt_d   = '0;
                        state_d = bus.bus_rw ? S_WDATA : S_RWAIT;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (!bus.bus_valid) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    addr_d = ADDR_WIDTH'({addr_q, bus.data_write});
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = rw_q ? S_WDATA : S_RWAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WDATA: begin
                if (!bus.bus_valid) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wsh_d = DATA_WIDTH'({wsh_q, bus.data_write});
                    if (cnt_q == DATA_LAST) begin
                        mem_we    = 1'b1;
                        wr_done_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RWAIT: begin
                if (!bus.bus_valid) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rsh_d   = mem_q[addr_q];
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (!bus.bus_valid) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rsh_d = DATA_WIDTH'({rsh_q, 2'b00});
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                // A strobe held past the frame end is not a new frame; the
                // master must drop it for at least one cycle first.
                if (!bus.bus_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wsh_q        <= '0;
            rsh_q        <= '0;
            rw_q         <= 1'b0;
            wr_done_q    <= 1'b0;
            abort_q      <= 1'b0;
            last_wdata_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wsh_q     <= wsh_d;
            rsh_q     <= rsh_d;
            rw_q      <= rw_d;
            wr_done_q <= wr_done_d;
            abort_q   <= abort_d;
            if (mem_we) begin
                // wsh_d already holds the final beat shifted in.
                mem_q[addr_q] <= wsh_d;
                last_wdata_q  <= wsh_d;
            end
        end
    end

`ifdef BUS_SLAVE_ABORT_CNT_EN
    logic [7:0] abort_cnt_q;

    // Counts on the same edge that launches the frame_abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_cnt_q <= 8'd0;
        end else if (abort_d && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_q <= abort_cnt_q + 8'd1;
        end
    end

    assign abort_count = abort_cnt_q;
`endif

    // Read lane is driven straight from state so an abort or reset silences
    // it in the very cycle the state leaves RDATA.
    assign bus.read_valid = (state_q == S_RDATA);
    assign bus.data_read  = (state_q == S_RDATA) ? rsh_q[DATA_WIDTH-1 -: 2] : 2'b00;
    assign wr_done        = wr_done_q;
    assign frame_abort    = abort_q;
    assign busy           = (state_q != S_IDLE);
    assign last_wdata     = last_wdata_q;
    assign dbg_state_o    = state_q;

endmodule
